reg_scoreboard: RTL and testbench

- Parametrised register-busy scoreboard for the register-file write path.
- Decodes the issuing instruction's destination register to a one-hot vector and marks that register pending.
- Clears the pending mark when the matching writeback retires.
- Checks up to NSRC source registers against pending writes and raises a stall for the issue stage.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/onehot_decoder.sv | 15 +
 rtl/reg_scoreboard.sv | 103 ++++++++++
 tb/tb_reg_scoreboard.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and a reference one-hot decode helper.
package regfile_pkg;

  localparam int unsigned DEF_ADDR_W   = 4;
  localparam int unsigned DEF_NREGS    = 2**DEF_ADDR_W;
  localparam int unsigned DEF_ZERO_REG = 1;

  function automatic logic [DEF_NREGS-1:0] onehot_dec(input logic [DEF_ADDR_W-1:0] addr);
    logic [DEF_NREGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Enabled binary-to-one-hot decoder, AW address bits to 2**AW lines.
module onehot_decoder #(
  parameter int unsigned AW = 4
) (
  input  logic              en,
  input  logic [AW-1:0]     addr,
  output logic [2**AW-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: counts outstanding writes per register and
// stalls issue on RAW hazards or when a destination counter would overflow.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned NREGS   = 2**ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic                   issue_wr,
  input  logic [ADDR_W-1:0]      issue_dest,
  input  logic [NSRC-1:0]        src_used,
  input  logic [NSRC*ADDR_W-1:0] src_addr,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_dest,
  output logic                   stall,
  output logic                   issue_fire,
  output logic [NSRC-1:0]        src_hazard,
  output logic [NREGS-1:0]       busy,
  output logic [NREGS-1:0]       dest_onehot,
  output logic                   wb_err
);

  // Clears bit 0 of the decode vectors when register 0 is hardwired.
  localparam logic [NREGS-1:0] ZMASK = (ZERO_REG != 0) ? ~NREGS'(1) : '1;

  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] inc_raw, dec_raw, inc_vec, dec_vec;
  logic             inc_en;
  logic             sat;
  logic             wb_zero_err;

  onehot_decoder #(.AW(ADDR_W)) u_issue_dec (
    .en     (inc_en),
    .addr   (issue_dest),
    .onehot (inc_raw)
  );

  onehot_decoder #(.AW(ADDR_W)) u_wb_dec (
    .en     (wb_valid),
    .addr   (wb_dest),
    .onehot (dec_raw)
  );

  assign inc_vec = inc_raw & ZMASK;
  assign dec_vec = dec_raw & ZMASK;

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREGS; r++) busy[r] = (cnt[r] != '0);
  end

  // Per-port hazard; bypass only when this writeback retires the last pending write.
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [ADDR_W-1:0] sa;
    logic              byp;
    assign sa  = src_addr[k*ADDR_W +: ADDR_W];
    assign byp = (BYPASS != 0) && wb_valid && (wb_dest == sa) && (cnt[sa] == CNT_W'(1));
    assign src_hazard[k] = src_used[k] && busy[sa] && !byp
                           && !((ZERO_REG != 0) && (sa == '0));
  end

  assign sat = issue_wr && (cnt[issue_dest] == {CNT_W{1'b1}})
               && !(wb_valid && (wb_dest == issue_dest));

  assign stall      = issue_valid && ((|src_hazard) || sat);
  assign issue_fire = issue_valid && !stall;
  assign inc_en     = issue_fire && issue_wr;

  assign wb_zero_err = wb_valid && (cnt[wb_dest] == '0)
                       && !((ZERO_REG != 0) && (wb_dest == '0));

  // Counters never wrap: increments are held off by sat, decrements at zero are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_onehot <= '0;
      wb_err      <= 1'b0;
    end else begin
      dest_onehot <= inc_vec;
      if (wb_zero_err) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expected values.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_wr;
  logic [3:0]  issue_dest;
  logic [1:0]  src_used;
  logic [7:0]  src_addr;
  logic        wb_valid;
  logic [3:0]  wb_dest;
  logic        stall, issue_fire;
  logic [1:0]  src_hazard;
  logic [15:0] busy, dest_onehot;
  logic        wb_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_wr    (issue_wr),
    .issue_dest  (issue_dest),
    .src_used    (src_used),
    .src_addr    (src_addr),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .stall       (stall),
    .issue_fire  (issue_fire),
    .src_hazard  (src_hazard),
    .busy        (busy),
    .dest_onehot (dest_onehot),
    .wb_err      (wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wr = 1'b0; issue_dest = '0;
    src_used = '0; src_addr = '0; wb_valid = 1'b0; wb_dest = '0;
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks at 2ns.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue_w(input logic [3:0] d);
    idle(); issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = d;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dest_onehot", 32'(dest_onehot), 32'h0);
    chk("rst_wb_err", 32'(wb_err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_stall", 32'(stall), 32'h0);

    // RAW hazard on r5 with writeback bypass
    issue_w(4'd5); #1;
    chk("raw_first_fire", 32'(issue_fire), 32'h1);
    step();
    chk("raw_dest_onehot", 32'(dest_onehot), 32'h0020);
    chk("raw_busy", 32'(busy), 32'h0020);
    idle(); issue_valid = 1'b1; src_used = 2'b01; src_addr = {4'd0, 4'd5}; #1;
    chk("raw_stall", 32'(stall), 32'h1);
    chk("raw_src_hazard", 32'(src_hazard), 32'h1);
    chk("raw_no_fire", 32'(issue_fire), 32'h0);
    wb_valid = 1'b1; wb_dest = 4'd5; #1;
    chk("raw_bypass_stall", 32'(stall), 32'h0);
    chk("raw_bypass_hazard", 32'(src_hazard), 32'h0);
    chk("raw_bypass_fire", 32'(issue_fire), 32'h1);
    step();
    chk("raw_busy_cleared", 32'(busy), 32'h0);
    chk("raw_dest_onehot_nowr", 32'(dest_onehot), 32'h0);

    // Saturation on r3 (max 3 in flight)
    for (int i = 0; i < 3; i++) begin
      issue_w(4'd3); step();
    end
    chk("sat_busy", 32'(busy), 32'h0008);
    issue_w(4'd3); #1;
    chk("sat_stall", 32'(stall), 32'h1);
    chk("sat_no_fire", 32'(issue_fire), 32'h0);
    wb_valid = 1'b1; wb_dest = 4'd3; #1;
    chk("sat_wb_stall", 32'(stall), 32'h0);
    step();
    chk("sat_wb_dest_onehot", 32'(dest_onehot), 32'h0008);
    // Count is still 3: bypass must not apply until the last pending write retires
    for (int i = 3; i >= 1; i--) begin
      idle(); issue_valid = 1'b1; src_used = 2'b10; src_addr = {4'd3, 4'd0};
      wb_valid = 1'b1; wb_dest = 4'd3; #1;
      chk($sformatf("sat_drain_stall_cnt%0d", i), 32'(stall), (i == 1) ? 32'h0 : 32'h1);
      step();
    end
    chk("sat_drained_busy", 32'(busy), 32'h0);
    chk("sat_drained_wb_err", 32'(wb_err), 32'h0);

    // Zero register is never busy and exempt from wb_err
    issue_w(4'd0); #1;
    chk("zero_fire", 32'(issue_fire), 32'h1);
    step();
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_dest_onehot", 32'(dest_onehot), 32'h0);
    idle(); issue_valid = 1'b1; src_used = 2'b01; src_addr = 8'h00; #1;
    chk("zero_src_stall", 32'(stall), 32'h0);
    idle(); wb_valid = 1'b1; wb_dest = 4'd0;
    step();
    chk("zero_wb_err", 32'(wb_err), 32'h0);

    // Spurious writeback to r9
    idle(); wb_valid = 1'b1; wb_dest = 4'd9;
    step();
    chk("spur_wb_err", 32'(wb_err), 32'h1);
    chk("spur_busy", 32'(busy), 32'h0);
    idle(); step(); step();
    chk("spur_wb_err_sticky", 32'(wb_err), 32'h1);
    issue_w(4'd9); step();
    chk("spur_cnt9_from0", 32'(busy), 32'h0200);
    idle(); wb_valid = 1'b1; wb_dest = 4'd9; step();
    chk("spur_cnt9_clear", 32'(busy), 32'h0);
    chk("spur_wb_err_still", 32'(wb_err), 32'h1);

    // Async reset with r2, r7, r15 pending
    issue_w(4'd2);  step();
    issue_w(4'd7);  step();
    issue_w(4'd15); step();
    idle();
    chk("ar_busy_before", 32'(busy), 32'h8084);
    #2; rst_n = 1'b0; #1;
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_wb_err", 32'(wb_err), 32'h0);
    chk("ar_dest_onehot", 32'(dest_onehot), 32'h0);
    #1; rst_n = 1'b1;
    step();
    issue_valid = 1'b1; src_used = 2'b01; src_addr = {4'd0, 4'd7}; #1;
    chk("ar_src7_stall", 32'(stall), 32'h0);
    chk("ar_src7_fire", 32'(issue_fire), 32'h1);
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
